// File: rtl/btb_pkg.sv
// Shared types and address helpers for the branch target buffer.
package btb_pkg;

  localparam int unsigned BTB_PC_SIZE    = 12;
  localparam int unsigned BTB_INDEX_BITS = 4;
  localparam int unsigned BTB_TAG_BITS   = BTB_PC_SIZE - BTB_INDEX_BITS - 2;

  typedef enum logic {
    BTB_IDLE  = 1'b0,
    BTB_FLUSH = 1'b1
  } btb_state_e;

  // Entry index: word-address bits directly above the byte offset.
  function automatic logic [BTB_INDEX_BITS-1:0] btb_index(input logic [BTB_PC_SIZE-1:0] pc);
    return BTB_INDEX_BITS'(pc >> 2);
  endfunction

  // Tag: everything above the index.
  function automatic logic [BTB_TAG_BITS-1:0] btb_tag(input logic [BTB_PC_SIZE-1:0] pc);
    return BTB_TAG_BITS'(pc >> (BTB_INDEX_BITS + 2));
  endfunction

endpackage

// File: rtl/btb_storage.sv
// Direct-mapped entry storage: valid/tag/target arrays with one read,
// one write and one clear port. Only the valid bits are reset.
module btb_storage #(
  parameter int unsigned PC_SIZE    = 12,
  parameter int unsigned INDEX_BITS = 4,
  localparam int unsigned TAG_W     = PC_SIZE - INDEX_BITS - 2,
  localparam int unsigned ENTRIES   = 1 << INDEX_BITS
) (
  input  logic                  CLK,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid_c,
  output logic [TAG_W-1:0]      rd_tag_c,
  output logic [PC_SIZE-1:0]    rd_target_c,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [PC_SIZE-1:0]    wr_target,
  input  logic                  clr_all,
  input  logic                  clr_en,
  input  logic [INDEX_BITS-1:0] clr_idx
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_SIZE-1:0] target_q [ENTRIES];

  // Valid bits: all-clear wins, then write sets, then single-entry clear.
  always_ff @(posedge CLK) begin
    if (clr_all) begin
      valid_q <= '0;
    end else begin
      if (wr_en)  valid_q[wr_idx]  <= 1'b1;
      if (clr_en) valid_q[clr_idx] <= 1'b0;
    end
  end

  // Tag and target payload; no reset needed since valid gates every use.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

  assign rd_valid_c  = valid_q[rd_idx];
  assign rd_tag_c    = tag_q[rd_idx];
  assign rd_target_c = target_q[rd_idx];

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB for the IF stage: same-cycle lookup with an EX-update
// bypass, and a walking flush that invalidates one entry per cycle.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int unsigned PC_SIZE    = 12,
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [PC_SIZE-1:0] lookup_pc,
  output logic               hit,
  output logic [PC_SIZE-1:0] predicted_target,
  input  logic               update_valid,
  input  logic [PC_SIZE-1:0] update_pc,
  input  logic [PC_SIZE-1:0] update_target,
  input  logic               flush_req,
  output logic               busy
);

  localparam int unsigned TAG_W   = PC_SIZE - INDEX_BITS - 2;
  localparam int unsigned WORD_W  = PC_SIZE - 2;
  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  btb_state_e              state_q, state_d;
  logic [INDEX_BITS-1:0]   flush_ptr_q, flush_ptr_d;
  logic                    clr_en_c;

  logic [INDEX_BITS-1:0]   lk_idx_c, up_idx_c;
  logic [TAG_W-1:0]        lk_tag_c, up_tag_c;
  logic                    rd_valid_c;
  logic [TAG_W-1:0]        rd_tag_c;
  logic [PC_SIZE-1:0]      rd_target_c;
  logic                    upd_en_c, bypass_c, store_hit_c;

  assign busy = (state_q == BTB_FLUSH);

  // Address split; the byte offset bits fall off the shift.
  assign lk_idx_c = INDEX_BITS'(lookup_pc >> 2);
  assign up_idx_c = INDEX_BITS'(update_pc >> 2);
  assign lk_tag_c = TAG_W'(lookup_pc >> (INDEX_BITS + 2));
  assign up_tag_c = TAG_W'(update_pc >> (INDEX_BITS + 2));

  // Updates are dropped during a flush and lose to reset.
  assign upd_en_c = update_valid && !busy;

  btb_storage #(
    .PC_SIZE    (PC_SIZE),
    .INDEX_BITS (INDEX_BITS)
  ) u_storage (
    .CLK         (CLK),
    .rd_idx      (lk_idx_c),
    .rd_valid_c  (rd_valid_c),
    .rd_tag_c    (rd_tag_c),
    .rd_target_c (rd_target_c),
    .wr_en       (upd_en_c && !RESET),
    .wr_idx      (up_idx_c),
    .wr_tag      (up_tag_c),
    .wr_target   (update_target),
    .clr_all     (RESET),
    .clr_en      (clr_en_c),
    .clr_idx     (flush_ptr_q)
  );

  // Lookup with same-word bypass from the EX update; masked while flushing.
  always_comb begin
    bypass_c    = upd_en_c && (WORD_W'(update_pc >> 2) == WORD_W'(lookup_pc >> 2));
    store_hit_c = !busy && rd_valid_c && (rd_tag_c == lk_tag_c);
    hit         = bypass_c || store_hit_c;
    predicted_target = '0;
    if (bypass_c)         predicted_target = update_target;
    else if (store_hit_c) predicted_target = rd_target_c;
  end

  // Flush FSM state and walk pointer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= BTB_IDLE;
      flush_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_ptr_q <= flush_ptr_d;
    end
  end

  // Flush FSM next state: walk every index once, requests mid-walk ignored.
  always_comb begin
    state_d     = state_q;
    flush_ptr_d = flush_ptr_q;
    clr_en_c    = 1'b0;
    case (state_q)
      BTB_IDLE: begin
        if (flush_req) begin
          state_d     = BTB_FLUSH;
          flush_ptr_d = '0;
        end
      end
      BTB_FLUSH: begin
        clr_en_c    = 1'b1;
        flush_ptr_d = flush_ptr_q + INDEX_BITS'(1);
        if (flush_ptr_q == INDEX_BITS'(ENTRIES - 1)) state_d = BTB_IDLE;
      end
      default: state_d = BTB_IDLE;
    endcase
  end

endmodule
